ntt_mem_seq: RTL and testbench

NTT_MEM_SEQ -- requirements
Module: ntt_mem_seq

---
 rtl/ntt_pkg.sv | 15 +
 rtl/ntt_idx_gen.sv | 58 +++++
 rtl/ntt_mem_seq.sv | 132 +++++++++++++
 tb/tb_ntt_mem_seq.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared sizing constants and sequencer state encoding for the in-place NTT datapath.
package ntt_pkg;
  localparam int DATA_WIDTH = 12;
  localparam int ADW        = 5;
  localparam int N          = 2**ADW;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_ISSUE,
    ST_WAIT,
    ST_WB,
    ST_FIN
  } state_t;
endpackage

// File: rtl/ntt_idx_gen.sv
// Cooley-Tukey loop counters: walks len/start/j and the twiddle index k for one pass.
module ntt_idx_gen #(
  parameter int ADW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           init,
  input  logic           step,
  output logic [ADW-1:0] j,
  output logic [ADW-1:0] j_len,
  output logic [ADW-1:0] k,
  output logic           last
);
  localparam logic [ADW:0]   NUM       = (ADW+1)'(2**ADW);
  localparam logic [ADW-1:0] FIRST_LEN = ADW'(2**(ADW-1));
  localparam logic [ADW-1:0] LAST_J    = ADW'(2**ADW - 2);

  logic [ADW-1:0] len_q, start_q, j_q, k_q;
  logic [ADW:0]   next_start;
  logic           grp_end;

  // next_start needs one extra bit so the end of a stage (start + 2*len == N) is visible
  assign next_start = {1'b0, start_q} + {len_q, 1'b0};
  assign grp_end    = (j_q + ADW'(1)) == (start_q + len_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q   <= '0;
      start_q <= '0;
      j_q     <= '0;
      k_q     <= ADW'(1);
    end else if (init) begin
      len_q   <= FIRST_LEN;
      start_q <= '0;
      j_q     <= '0;
      k_q     <= ADW'(1);
    end else if (step) begin
      if (grp_end) begin
        k_q <= k_q + ADW'(1);
        if (next_start == NUM) begin
          len_q   <= len_q >> 1;
          start_q <= '0;
          j_q     <= '0;
        end else begin
          start_q <= next_start[ADW-1:0];
          j_q     <= next_start[ADW-1:0];
        end
      end else begin
        j_q <= j_q + ADW'(1);
      end
    end
  end

  assign j     = j_q;
  assign j_len = j_q + len_q;
  assign k     = k_q;
  assign last  = (len_q == ADW'(1)) && (j_q == LAST_J);
endmodule

// File: rtl/ntt_mem_seq.sv
// Sequencer for one in-place forward NTT pass over a dual-port coefficient RAM,
// handing each (j, j+len) pair to an external butterfly and writing the results back.
module ntt_mem_seq #(
  parameter int DATA_WIDTH = ntt_pkg::DATA_WIDTH,
  parameter int ADW        = ntt_pkg::ADW
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  we_a_o,
  output logic [ADW-1:0]        addr_a_o,
  output logic [DATA_WIDTH-1:0] din_a_o,
  output logic                  we_b_o,
  output logic [ADW-1:0]        addr_b_o,
  output logic [DATA_WIDTH-1:0] din_b_o,
  input  logic [DATA_WIDTH-1:0] dout_a_i,
  input  logic [DATA_WIDTH-1:0] dout_b_i,
  output logic                  bf_valid_o,
  output logic [DATA_WIDTH-1:0] bf_u_o,
  output logic [DATA_WIDTH-1:0] bf_v_o,
  output logic [ADW-1:0]        bf_zeta_idx_o,
  input  logic                  bf_valid_i,
  input  logic [DATA_WIDTH-1:0] bf_u_i,
  input  logic [DATA_WIDTH-1:0] bf_v_i
);
  import ntt_pkg::*;

  // Butterfly handshake: bf_valid_o pulses for exactly one cycle per operand pair;
  // the unit answers with a single bf_valid_i pulse, which is only honoured in ST_WAIT.
  state_t                state_q, state_d;
  logic                  idx_init, idx_step, idx_last;
  logic [ADW-1:0]        idx_j, idx_jl, idx_k;
  logic [DATA_WIDTH-1:0] res_u_q, res_v_q;

  ntt_idx_gen #(.ADW(ADW)) u_idx (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .init  (idx_init),
    .step  (idx_step),
    .j     (idx_j),
    .j_len (idx_jl),
    .k     (idx_k),
    .last  (idx_last)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      res_u_q <= '0;
      res_v_q <= '0;
    end else if (state_q == ST_WAIT && bf_valid_i) begin
      res_u_q <= bf_u_i;
      res_v_q <= bf_v_i;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_init      = 1'b0;
    idx_step      = 1'b0;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    we_a_o        = 1'b0;
    we_b_o        = 1'b0;
    addr_a_o      = '0;
    addr_b_o      = '0;
    din_a_o       = '0;
    din_b_o       = '0;
    bf_valid_o    = 1'b0;
    bf_u_o        = '0;
    bf_v_o        = '0;
    bf_zeta_idx_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          idx_init = 1'b1;
          state_d  = ST_RD;
        end
      end
      ST_RD: begin
        busy_o   = 1'b1;
        addr_a_o = idx_j;
        addr_b_o = idx_jl;
        state_d  = ST_ISSUE;
      end
      ST_ISSUE: begin
        busy_o        = 1'b1;
        bf_valid_o    = 1'b1;
        bf_u_o        = dout_a_i;
        bf_v_o        = dout_b_i;
        bf_zeta_idx_o = idx_k;
        state_d       = ST_WAIT;
      end
      ST_WAIT: begin
        busy_o = 1'b1;
        if (bf_valid_i) state_d = ST_WB;
      end
      ST_WB: begin
        busy_o   = 1'b1;
        we_a_o   = 1'b1;
        we_b_o   = 1'b1;
        addr_a_o = idx_j;
        addr_b_o = idx_jl;
        din_a_o  = res_u_q;
        din_b_o  = res_v_q;
        if (idx_last) begin
          state_d = ST_FIN;
        end else begin
          idx_step = 1'b1;
          state_d  = ST_RD;
        end
      end
      ST_FIN: begin
        done_o = 1'b1;
        // a start seen here chains straight into the next pass
        if (start_i) begin
          idx_init = 1'b1;
          state_d  = ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_ntt_mem_seq.sv
// Directed bench for ntt_mem_seq: RAM model, configurable butterfly stub, trace monitor,
// and a Kyber-zeta software NTT for the end-to-end comparison.
module tb_ntt_mem_seq;
  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        rst_ni, start_i;
  logic        busy_o, done_o, we_a_o, we_b_o, bf_valid_o, bf_valid_i;
  logic [4:0]  addr_a_o, addr_b_o, bf_zeta_idx_o;
  logic [11:0] din_a_o, din_b_o, dout_a_i, dout_b_i, bf_u_o, bf_v_o, bf_u_i, bf_v_i;

  always #5 clk = ~clk;

  ntt_mem_seq dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .we_a_o(we_a_o), .addr_a_o(addr_a_o), .din_a_o(din_a_o),
    .we_b_o(we_b_o), .addr_b_o(addr_b_o), .din_b_o(din_b_o),
    .dout_a_i(dout_a_i), .dout_b_i(dout_b_i),
    .bf_valid_o(bf_valid_o), .bf_u_o(bf_u_o), .bf_v_o(bf_v_o), .bf_zeta_idx_o(bf_zeta_idx_o),
    .bf_valid_i(bf_valid_i), .bf_u_i(bf_u_i), .bf_v_i(bf_v_i)
  );

  // bench knobs, written only by the stimulus block
  int          lat = 1;
  bit          kyber_mode = 1'b0;
  bit          spur_en = 1'b0;
  bit          load_req = 1'b0;
  logic [11:0] init_vec [32];

  function automatic int zeta(input int k);
    int e, r;
    e = 0;
    for (int b = 0; b < 7; b++) e = e | (((k >> b) & 1) << (6 - b));
    r = 1;
    for (int i = 0; i < e; i++) r = (r * 17) % Q;
    return r;
  endfunction

  function automatic logic [23:0] bfly(input int u, input int v, input int k);
    int t, nu, nv;
    t  = (zeta(k) * v) % Q;
    nu = (u + t) % Q;
    nv = (u - t + Q) % Q;
    return {nu[11:0], nv[11:0]};
  endfunction

  // dual-port RAM, one-cycle read latency
  logic [11:0] ram [32];
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 32; i++) ram[i] <= init_vec[i];
    end else begin
      if (we_a_o) ram[addr_a_o] <= din_a_o;
      if (we_b_o) ram[addr_b_o] <= din_b_o;
    end
    dout_a_i <= ram[addr_a_o];
    dout_b_i <= ram[addr_b_o];
  end

  // butterfly stub with latency lat; optional junk pulse in the cycle after each write-back
  int          cnt = 0;
  logic        stub_v = 1'b0, spur_v = 1'b0;
  logic [11:0] pu = '0, pv = '0;
  always @(posedge clk) begin
    stub_v <= 1'b0;
    spur_v <= 1'b0;
    if (bf_valid_o) begin
      if (kyber_mode) {pu, pv} <= bfly(int'(bf_u_o), int'(bf_v_o), int'(bf_zeta_idx_o));
      else            {pu, pv} <= {bf_u_o, bf_v_o};
      if (lat <= 1) stub_v <= 1'b1;
      else          cnt <= lat - 1;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) stub_v <= 1'b1;
    end
    if (spur_en && we_a_o) spur_v <= 1'b1;
  end
  assign bf_valid_i = stub_v | spur_v;
  assign bf_u_i     = spur_v ? 12'hA5A : pu;
  assign bf_v_i     = spur_v ? 12'h5A5 : pv;

  // free-running monitor; the stimulus block works with differences
  int         busy_cnt = 0, done_cnt = 0, wr_cnt = 0, iss_cnt = 0;
  logic [4:0] prev_a = '0, prev_b = '0;
  logic [4:0] tr_a [1024], tr_b [1024], tr_k [1024];
  always @(negedge clk) begin
    if (busy_o) busy_cnt <= busy_cnt + 1;
    if (done_o) done_cnt <= done_cnt + 1;
    if (we_a_o || we_b_o) wr_cnt <= wr_cnt + 1;
    if (bf_valid_o) begin
      tr_a[iss_cnt % 1024] <= prev_a;
      tr_b[iss_cnt % 1024] <= prev_b;
      tr_k[iss_cnt % 1024] <= bf_zeta_idx_o;
      iss_cnt <= iss_cnt + 1;
    end
    prev_a <= addr_a_o;
    prev_b <= addr_b_o;
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (done_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  function automatic logic [31:0] trace(input int idx);
    return {17'd0, tr_a[idx % 1024], tr_b[idx % 1024], tr_k[idx % 1024]};
  endfunction

  function automatic logic [31:0] pair(input int a, input int b, input int k);
    return {17'd0, a[4:0], b[4:0], k[4:0]};
  endfunction

  function automatic int ram_diffs();
    int m = 0;
    for (int i = 0; i < 32; i++) if (ram[i] !== init_vec[i]) m++;
    return m;
  endfunction

  int          b0, d0, w0, i0, seen, t, z, kk;
  bit          ok;
  int          gold [32];
  logic [11:0] exp_q [$];

  initial begin
    rst_ni  = 1'b0;
    start_i = 1'b0;
    for (int i = 0; i < 32; i++) init_vec[i] = 12'((i * 97 + 5) % Q);
    repeat (3) tick();

    check("rst_ctrl", {28'd0, busy_o, done_o, we_a_o, we_b_o}, 32'd0);
    check("rst_bf", {31'd0, bf_valid_o}, 32'd0);
    check("rst_addr", {17'd0, addr_a_o, addr_b_o, bf_zeta_idx_o}, 32'd0);
    check("rst_data", {8'd0, din_a_o, din_b_o}, 32'd0);

    rst_ni   = 1'b1;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    tick();

    // identity butterfly, L=1
    b0 = busy_cnt; d0 = done_cnt; w0 = wr_cnt; i0 = iss_cnt;
    pulse_start();
    check("t1_first_rd", {20'd0, busy_o, 1'b0, addr_a_o, addr_b_o}, {20'd0, 1'b1, 1'b0, 5'd0, 5'd16});
    wait_done(1000, ok);
    check("t1_done_seen", {31'd0, ok}, 32'd1);
    check("t1_fin_busy", {31'd0, busy_o}, 32'd0);
    tick(); tick();
    check("t1_busy_cycles", busy_cnt - b0, 32'd320);
    check("t1_done_count", done_cnt - d0, 32'd1);
    check("t1_write_cycles", wr_cnt - w0, 32'd80);
    check("t1_issues", iss_cnt - i0, 32'd80);
    check("t1_iss0", trace(i0), pair(0, 16, 1));
    check("t1_iss1", trace(i0 + 1), pair(1, 17, 1));
    check("t1_iss2", trace(i0 + 2), pair(2, 18, 1));
    check("t1_len8_a", trace(i0 + 16), pair(0, 8, 2));
    check("t1_len8_b", trace(i0 + 24), pair(16, 24, 3));
    check("t1_last", trace(i0 + 79), pair(30, 31, 31));
    check("t1_ram_same", ram_diffs(), 32'd0);

    // L=5 stall plus junk valid pulses in RD
    lat = 5; spur_en = 1'b1;
    b0 = busy_cnt; d0 = done_cnt; w0 = wr_cnt; i0 = iss_cnt;
    pulse_start();
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      if (bf_valid_o) seen = 1;
      else tick();
    end
    check("t2_issue_seen", seen, 32'd1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t2_wait_hold", {28'd0, busy_o, we_a_o, we_b_o, bf_valid_o}, 32'b1000);
    end
    tick();
    check("t2_wb", {20'd0, we_a_o, we_b_o, addr_a_o, addr_b_o}, {20'd0, 2'b11, 5'd0, 5'd16});
    wait_done(2000, ok);
    check("t2_done_seen", {31'd0, ok}, 32'd1);
    tick(); tick();
    check("t2_busy_cycles", busy_cnt - b0, 32'd640);
    check("t2_write_cycles", wr_cnt - w0, 32'd80);
    check("t2_done_count", done_cnt - d0, 32'd1);
    check("t2_ram_same", ram_diffs(), 32'd0);
    lat = 1; spur_en = 1'b0;

    // reset during butterfly 40
    d0 = done_cnt; w0 = wr_cnt;
    pulse_start();
    seen = 0;
    for (int c = 0; c < 400 && seen < 40; c++) begin
      if (bf_valid_o) seen++;
      if (seen < 40) tick();
    end
    check("t3_reached_40", seen, 32'd40);
    rst_ni = 1'b0;
    tick();
    check("t3_rst_ctrl", {27'd0, busy_o, done_o, we_a_o, we_b_o, bf_valid_o}, 32'd0);
    check("t3_rst_bus", {17'd0, addr_a_o, addr_b_o, bf_zeta_idx_o}, 32'd0);
    check("t3_rst_data", {8'd0, bf_u_o, bf_v_o}, 32'd0);
    tick();
    rst_ni = 1'b1;
    repeat (20) tick();
    check("t3_no_done", done_cnt - d0, 32'd0);
    check("t3_writes", wr_cnt - w0, 32'd39);
    i0 = iss_cnt; d0 = done_cnt;
    pulse_start();
    wait_done(1000, ok);
    check("t3_restart_done", {31'd0, ok}, 32'd1);
    tick(); tick();
    check("t3_restart_iss0", trace(i0), pair(0, 16, 1));
    check("t3_restart_dcnt", done_cnt - d0, 32'd1);

    // start held through a pass
    b0 = busy_cnt; d0 = done_cnt; i0 = iss_cnt;
    start_i = 1'b1;
    tick();
    wait_done(1000, ok);
    check("t4_done_seen", {31'd0, ok}, 32'd1);
    check("t4_fin", {30'd0, done_o, busy_o}, 32'b10);
    check("t4_busy_cycles", busy_cnt - b0, 32'd320);
    check("t4_issues", iss_cnt - i0, 32'd80);
    tick();
    check("t4_rechain", {20'd0, busy_o, done_o, addr_a_o, addr_b_o}, {20'd0, 1'b1, 1'b0, 5'd0, 5'd16});
    start_i = 1'b0;
    wait_done(1000, ok);
    check("t4_done2_seen", {31'd0, ok}, 32'd1);
    tick(); tick();
    check("t4_done_count", done_cnt - d0, 32'd2);
    check("t4_issues_total", iss_cnt - i0, 32'd160);

    // Kyber butterfly against a software NTT
    kyber_mode = 1'b1; lat = 2;
    for (int i = 0; i < 32; i++) begin
      gold[i]     = $urandom_range(0, Q - 1);
      init_vec[i] = 12'(gold[i]);
    end
    kk = 1;
    for (int len = 16; len >= 1; len = len / 2) begin
      for (int s = 0; s < 32; s += 2 * len) begin
        z = zeta(kk);
        kk++;
        for (int j = s; j < s + len; j++) begin
          t = (z * gold[j + len]) % Q;
          gold[j + len] = (gold[j] - t + Q) % Q;
          gold[j]       = (gold[j] + t) % Q;
        end
      end
    end
    for (int i = 0; i < 32; i++) exp_q.push_back(12'(gold[i]));
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    tick();
    pulse_start();
    wait_done(1000, ok);
    check("t5_done_seen", {31'd0, ok}, 32'd1);
    tick(); tick();
    for (int i = 0; i < 32; i++) begin
      check($sformatf("t5_coef%0d", i), {20'd0, ram[i]}, {20'd0, exp_q.pop_front()});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
